io_led_sequencer: RTL

Controller that owns the trainer board's 8 DIP switches and 8 LEDs on the Mojo ExternalIO path. It synchronises and debounces `trainer_dip` and uses the top two debounced bits to select a display mode. It then sequences the LED bank: mirror, binary count, walking bit or blink. It replaces the direct DIP-to-LED wire in `mojo_top` and gives later CPU/IO bring-up a stable, glitch-free switch value plus a change strobe.

---
 rtl/io_led_sequencer.sv | 169 ++++++++++++++++
 1 files changed

// File: rtl/io_led_sequencer.sv
// rtl/io_led_sequencer.sv - DIP debounce plus LED mode sequencer (mirror/count/walk/blink)
// Optional feature macro: IO_LED_SEQ_BLINK_EN (undefined: mode 11 behaves as mirror)
module io_led_sequencer #(
    parameter int DB_CYCLES   = 50000,
    parameter int STEP_CYCLES = 12500000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] trainer_dip,
    output logic [7:0] led,
    output logic [7:0] dip_db,
    output logic       dip_changed,
    output logic [1:0] mode
);

    localparam int DBW = $clog2(DB_CYCLES + 1);
    localparam int SW  = $clog2(STEP_CYCLES);
    localparam logic [DBW-1:0] DB_LAST   = DBW'(DB_CYCLES - 1);
    localparam logic [DBW-1:0] DB_DONE   = DBW'(DB_CYCLES);
    localparam logic [SW-1:0]  STEP_LAST = SW'(STEP_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2
    } state_t;

    logic [7:0]     sync1;
    logic [7:0]     sync2;
    logic [7:0]     cand;
    logic [DBW-1:0] db_cnt;
    logic           qualify;

    state_t         state;
    logic [SW-1:0]  step;
    logic [7:0]     pattern;
    logic           tick;
    logic           mode_change;
    logic           is_mirror;
`ifdef IO_LED_SEQ_BLINK_EN
    logic           phase;
    logic           phase_next;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= 8'h00;
            sync2 <= 8'h00;
        end else begin
            sync1 <= trainer_dip;
            sync2 <= sync1;
        end
    end

    // Counter saturates at DB_CYCLES so a held value qualifies exactly once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cand   <= 8'h00;
            db_cnt <= '0;
        end else if (sync2 != cand) begin
            cand   <= sync2;
            db_cnt <= '0;
        end else if (db_cnt != DB_DONE) begin
            db_cnt <= db_cnt + 1'b1;
        end
    end

    assign qualify = (sync2 == cand) && (db_cnt == DB_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dip_db      <= 8'h00;
            dip_changed <= 1'b0;
        end else begin
            dip_changed <= qualify && (cand != dip_db);
            if (qualify) begin
                dip_db <= cand;
            end
        end
    end

    assign tick        = (step == STEP_LAST);
    assign mode_change = dip_changed && (dip_db[7:6] != mode);

`ifdef IO_LED_SEQ_BLINK_EN
    assign is_mirror  = (mode == 2'b00);
    assign phase_next = tick ? ~phase : phase;
`else
    assign is_mirror  = (mode == 2'b00) || (mode == 2'b11);
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            mode    <= 2'b00;
            step    <= '0;
            pattern <= 8'h00;
            led     <= 8'h00;
`ifdef IO_LED_SEQ_BLINK_EN
            phase   <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    led <= 8'h00;
                    if (qualify) begin
                        state <= LOAD;
                    end
                end
                LOAD: begin
                    mode  <= dip_db[7:6];
                    step  <= '0;
                    state <= RUN;
                    case (dip_db[7:6])
                        2'b01: begin
                            pattern <= 8'h00;
                            led     <= 8'h00;
                        end
                        2'b10: begin
                            pattern <= 8'h01;
                            led     <= 8'h01;
                        end
`ifdef IO_LED_SEQ_BLINK_EN
                        2'b11: begin
                            phase <= 1'b1;
                            led   <= {2'b00, dip_db[5:0]};
                        end
`endif
                        default: led <= dip_db;
                    endcase
                end
                RUN: begin
                    // A mode change discards any coincident tick.
                    if (mode_change) begin
                        state <= LOAD;
                        if (is_mirror) begin
                            led <= dip_db;
                        end
                    end else begin
                        step <= tick ? '0 : step + 1'b1;
                        case (mode)
                            2'b01: begin
                                if (tick) begin
                                    pattern <= pattern + 8'd1;
                                    led     <= pattern + 8'd1;
                                end
                            end
                            2'b10: begin
                                if (tick) begin
                                    pattern <= {pattern[6:0], pattern[7]};
                                    led     <= {pattern[6:0], pattern[7]};
                                end
                            end
`ifdef IO_LED_SEQ_BLINK_EN
                            2'b11: begin
                                phase <= phase_next;
                                led   <= phase_next ? {2'b00, dip_db[5:0]} : 8'h00;
                            end
`endif
                            default: led <= dip_db;
                        endcase
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
